// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the instruction decoders and pc_sequencer.
// master: decode side driving redirect requests; slave: the sequencer itself.
interface pc_sequencer_if #(
    parameter int unsigned AW = 32
);
    logic          int_req;
    logic [AW-1:0] int_vec;
    logic          stall;
    logic          branch;
    logic          zero;
    logic [AW-1:0] imm;
    logic          jump;
    logic [25:0]   jTarget;
    logic          call;
    logic          ret;
    logic          eret;
    logic [AW-1:0] pc;
    logic [AW-1:0] PCp4;
    logic [AW-1:0] epc;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_err;

    modport master (
        output int_req, int_vec, stall, branch, zero, imm,
               jump, jTarget, call, ret, eret,
        input  pc, PCp4, epc, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  int_req, int_vec, stall, branch, zero, imm,
               jump, jTarget, call, ret, eret,
        output pc, PCp4, epc, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with stall, return-address stack and interrupt vectoring.
// Optional PCSEQ_EPC_EN builds the exception-PC register and enables eret.
module pc_sequencer #(
    parameter int unsigned AW        = 32,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_VEC = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    localparam int unsigned   PW       = $clog2(RAS_DEPTH);
    localparam int unsigned   CW       = PW + 1;
    localparam logic [AW-1:0] RESET_PC = AW'(RESET_VEC) & ~AW'(3);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [PW-1:0] top_q, top_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          err_q, err_d;
    logic          push, pop;
    logic [AW-1:0] pc_p4, br_tgt, j_tgt;
    logic [AW-1:0] ras_mem [RAS_DEPTH];

`ifdef PCSEQ_EPC_EN
    logic [AW-1:0] epc_q, epc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) epc_q <= '0;
        else        epc_q <= epc_d;
    end

    assign bus.epc = epc_q;
`else
    logic unused_eret;

    assign unused_eret = bus.eret;
    assign bus.epc     = '0;
`endif

    // Redirect targets; jump keeps the upper PCp4 bits above the 28-bit region
    always_comb begin
        pc_p4        = pc_q + AW'(4);
        br_tgt       = pc_p4 + (bus.imm << 2);
        j_tgt        = pc_p4;
        j_tgt[27:0]  = {bus.jTarget, 2'b00};
    end

    // Next-PC priority select and RAS pointer/count update
    always_comb begin
        pc_d  = pc_p4;
        top_d = top_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
`ifdef PCSEQ_EPC_EN
        epc_d = epc_q;
`endif
        if (bus.int_req) begin
            pc_d = bus.int_vec & ~AW'(3);
`ifdef PCSEQ_EPC_EN
            epc_d = pc_q;
`endif
        end else if (bus.stall) begin
            pc_d = pc_q;
`ifdef PCSEQ_EPC_EN
        end else if (bus.eret) begin
            pc_d = epc_q;
`endif
        end else if (bus.ret) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                pc_d = ras_mem[top_q];
                pop  = 1'b1;
            end
        end else if (bus.jump || bus.call) begin
            pc_d = j_tgt;
            push = bus.call;
        end else if (bus.branch && bus.zero) begin
            pc_d = br_tgt;
        end

        // Push while full wraps onto the oldest slot and keeps the count saturated
        if (push) begin
            top_d = top_q + PW'(1);
            if (cnt_q == CNT_FULL) err_d = 1'b1;
            else                   cnt_d = cnt_q + CW'(1);
        end
        if (pop) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end

        full_d  = (cnt_d == CNT_FULL);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            top_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // Entry storage needs no reset; the count qualifies every read
    always_ff @(posedge clk) begin
        if (push) ras_mem[top_d] <= pc_p4;
    end

    assign bus.pc        = pc_q;
    assign bus.PCp4      = pc_p4;
    assign bus.ras_empty = empty_q;
    assign bus.ras_full  = full_q;
    assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (defaults: AW=32, RAS_DEPTH=4, RESET_VEC=128).
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    pc_sequencer_if #(.AW(32)) bus ();

    pc_sequencer #(
        .AW        (32),
        .RAS_DEPTH (4),
        .RESET_VEC (128)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.int_req = 1'b0;
        bus.int_vec = '0;
        bus.stall   = 1'b0;
        bus.branch  = 1'b0;
        bus.zero    = 1'b0;
        bus.imm     = '0;
        bus.jump    = 1'b0;
        bus.jTarget = '0;
        bus.call    = 1'b0;
        bus.ret     = 1'b0;
        bus.eret    = 1'b0;
    endtask

    task automatic do_call(input logic [25:0] jt, input logic [31:0] exp_pc, input string tag);
        idle();
        bus.call    = 1'b1;
        bus.jTarget = jt;
        step();
        check(tag, bus.pc, exp_pc);
    endtask

    task automatic do_ret(input logic [31:0] exp_pc, input string tag);
        idle();
        bus.ret = 1'b1;
        step();
        check(tag, bus.pc, exp_pc);
    endtask

    logic [31:0] stalled_pc;
    logic [31:0] pre_rst_pc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_pc",    bus.pc,        32'd128);
        check("rst_empty", {31'd0, bus.ras_empty}, 32'd1);
        check("rst_full",  {31'd0, bus.ras_full},  32'd0);
        check("rst_err",   {31'd0, bus.ras_err},   32'd0);
        check("rst_epc",   bus.epc,       32'd0);
        step();
        rst_n = 1'b1;

        repeat (3) step();
        check("free_pc",   bus.pc,   32'd140);
        check("free_pcp4", bus.PCp4, 32'd144);

        // Branch taken backwards, then not taken
        bus.branch = 1'b1; bus.zero = 1'b1; bus.imm = 32'hFFFF_FFFE;
        step();
        check("br_taken", bus.pc, 32'd136);
        bus.zero = 1'b0;
        step();
        check("br_not_taken", bus.pc, 32'd140);

        // Nested calls and returns
        idle(); bus.jump = 1'b1; bus.jTarget = 26'h40;
        step();
        check("jump_100", bus.pc, 32'h100);
        do_call(26'h80, 32'h200, "call1");
        check("call1_nonempty", {31'd0, bus.ras_empty}, 32'd0);
        do_call(26'hC0,  32'h300, "call2");
        do_call(26'h100, 32'h400, "call3");
        do_ret(32'h304, "ret1");
        do_ret(32'h204, "ret2");
        do_ret(32'h104, "ret3");
        check("ret_empty", {31'd0, bus.ras_empty}, 32'd1);
        check("ret_noerr", {31'd0, bus.ras_err},   32'd0);

        // Overflow: pushes 0x108, 0x404, 0x504, 0x604, 0x704
        do_call(26'h100, 32'h400, "ovf_c1");
        do_call(26'h140, 32'h500, "ovf_c2");
        do_call(26'h180, 32'h600, "ovf_c3");
        do_call(26'h1C0, 32'h700, "ovf_c4");
        check("ovf_full4", {31'd0, bus.ras_full}, 32'd1);
        check("ovf_err4",  {31'd0, bus.ras_err},  32'd0);
        do_call(26'h200, 32'h800, "ovf_c5");
        check("ovf_err5",  {31'd0, bus.ras_err},  32'd1);
        check("ovf_full5", {31'd0, bus.ras_full}, 32'd1);
        idle();
        step();
        check("ovf_err_clr", {31'd0, bus.ras_err}, 32'd0);
        check("ovf_free_pc", bus.pc, 32'h804);
        do_ret(32'h704, "ovf_r1");
        do_ret(32'h604, "ovf_r2");
        do_ret(32'h504, "ovf_r3");
        do_ret(32'h404, "ovf_r4");
        check("ovf_empty", {31'd0, bus.ras_empty}, 32'd1);
        do_ret(32'h408, "unf_pc");
        check("unf_err", {31'd0, bus.ras_err}, 32'd1);
        idle();
        step();
        check("unf_err_clr", {31'd0, bus.ras_err}, 32'd0);
        check("unf_free_pc", bus.pc, 32'h40C);

        // Stall, interrupt during stall, then eret
        stalled_pc = 32'h40C;
        bus.stall = 1'b1;
        bus.jump  = 1'b1;
        bus.jTarget = 26'h3;
        repeat (3) step();
        check("stall_pc", bus.pc, stalled_pc);
        bus.int_req = 1'b1; bus.int_vec = 32'h1F3;
        step();
        check("int_pc", bus.pc, 32'h1F0);
`ifdef PCSEQ_EPC_EN
        check("int_epc", bus.epc, stalled_pc);
`else
        check("int_epc", bus.epc, 32'd0);
`endif
        idle(); bus.eret = 1'b1;
        step();
`ifdef PCSEQ_EPC_EN
        check("eret_pc", bus.pc, stalled_pc);
        pre_rst_pc = stalled_pc;
`else
        check("eret_pc", bus.pc, 32'h1F4);
        check("eret_epc", bus.epc, 32'd0);
        pre_rst_pc = 32'h1F4;
`endif

        // Call then asynchronous reset between edges
        do_call(26'h80, 32'h200, "pre_rst_call");
        check("pre_rst_nonempty", {31'd0, bus.ras_empty}, 32'd0);
        check("pre_rst_from", pre_rst_pc + 32'd4 - 32'd4 + 32'd0 == pre_rst_pc ? bus.pc : 32'd0, 32'h200);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc",    bus.pc,    32'd128);
        check("arst_empty", {31'd0, bus.ras_empty}, 32'd1);
        check("arst_err",   {31'd0, bus.ras_err},   32'd0);
        check("arst_epc",   bus.epc,   32'd0);
        #3 rst_n = 1'b1;
        step();
        check("post_rst_pc", bus.pc, 32'd132);
        check("post_rst_empty", {31'd0, bus.ras_empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
